sprite_blitter: RTL and testbench

- Read-side master for the single-port sprite ROMs (24-bit RGB, synchronous read, 1-cycle latency).
- On a start pulse, walks a rectangular sprite region in ROM row by row and copies each pixel into the frame buffer at a screen position.
- Skips transparent-key pixels and clips at the screen edges; optional horizontal mirror for facing direction.
- Sits between game/animation control logic and the frame-buffer write port.

---
 rtl/sprite_blitter.sv | 145 ++++++++++++++
 tb/tb_sprite_blitter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite copy engine: reads a rectangular region from sprite ROM and writes it to the frame
// buffer at a screen position, dropping key-colour pixels and anything past the screen edge.
module sprite_blitter #(
   parameter int          ROM_AW    = 19,
   parameter int          FB_AW     = 19,
   parameter int          SCREEN_W  = 640,
   parameter int          SCREEN_H  = 480,
   parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [ROM_AW-1:0] base_addr,
   input  logic [7:0]        spr_w,
   input  logic [7:0]        spr_h,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic              flip_h,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic [FB_AW-1:0]  fb_addr,
   output logic [23:0]       fb_data,
   output logic              fb_we,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
   state_t state;

   logic [7:0]        w_q, h_q, col, row;
   logic [9:0]        px_q, py_q;
   logic              flip_q;
   logic [ROM_AW-1:0] row_base;
   logic [FB_AW-1:0]  fb_row;

   // issue stage (aligned with rom_addr) and data stage (aligned with rom_data)
   logic              rom_vld, last_q, vld_d;
   logic [FB_AW-1:0]  fb_q;
   logic [7:0]        col_q, row_q, col_d, row_d;

   logic              idle, iss, eol, is_last, cflip;
   logic [7:0]        cw, ch, ccol, crow, csel;
   logic [9:0]        cpx;
   logic [ROM_AW-1:0] crb;
   logic [FB_AW-1:0]  cfr;
   logic [10:0]       x_sum, y_sum;

   // The first address is issued straight from the request inputs on the accept edge.
   always_comb begin
      idle    = (state == IDLE);
      cw      = idle ? spr_w  : w_q;
      ch      = idle ? spr_h  : h_q;
      cflip   = idle ? flip_h : flip_q;
      cpx     = idle ? pos_x  : px_q;
      ccol    = idle ? 8'd0   : col;
      crow    = idle ? 8'd0   : row;
      crb     = idle ? base_addr : row_base;
      cfr     = idle ? FB_AW'(pos_y) * FB_AW'(SCREEN_W) : fb_row;
      csel    = cflip ? (cw - 8'd1 - ccol) : ccol;
      eol     = (ccol == cw - 8'd1);
      is_last = eol && (crow == ch - 8'd1);
      iss     = idle ? (start && spr_w != 8'd0 && spr_h != 8'd0)
                     : (state == RUN && !last_q);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr <= '0;  fb_q   <= '0;  fb_addr  <= '0;
         rom_vld  <= 1'b0; last_q <= 1'b0; vld_d   <= 1'b0;
         col   <= '0; row   <= '0; col_q  <= '0; row_q <= '0;
         col_d <= '0; row_d <= '0; row_base <= '0; fb_row <= '0;
         w_q   <= '0; h_q   <= '0; px_q   <= '0; py_q  <= '0; flip_q <= 1'b0;
      end else begin
         rom_vld <= iss;
         vld_d   <= rom_vld;
         fb_addr <= fb_q;
         col_d   <= col_q;
         row_d   <= row_q;
         if (iss) begin
            rom_addr <= crb + ROM_AW'(csel);
            fb_q     <= cfr + FB_AW'(cpx) + FB_AW'(ccol);
            col_q    <= ccol;
            row_q    <= crow;
            last_q   <= is_last;
            if (eol) begin
               col      <= 8'd0;
               row      <= crow + 8'd1;
               row_base <= crb + ROM_AW'(cw);
               fb_row   <= cfr + FB_AW'(SCREEN_W);
            end else begin
               col      <= ccol + 8'd1;
               row      <= crow;
               row_base <= crb;
               fb_row   <= cfr;
            end
         end
         if (idle && start) begin
            w_q    <= spr_w;
            h_q    <= spr_h;
            px_q   <= pos_x;
            py_q   <= pos_y;
            flip_q <= flip_h;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  if (spr_w == 8'd0 || spr_h == 8'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            RUN:
               if (last_q) state <= FLUSH;
            FLUSH: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // 11-bit sums so a pixel past the right edge never wraps onto the next line
   assign x_sum   = {1'b0, px_q} + {3'b0, col_d};
   assign y_sum   = {1'b0, py_q} + {3'b0, row_d};
   assign fb_data = rom_data;
   assign fb_we   = vld_d && (rom_data != KEY_COLOR) &&
                    (x_sum < 11'(SCREEN_W)) && (y_sum < 11'(SCREEN_H));

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: per-cycle log of each copy checked against hand tables.
module tb_sprite_blitter;
   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic [18:0] base_addr = '0;
   logic [7:0]  spr_w = '0, spr_h = '0;
   logic [9:0]  pos_x = '0, pos_y = '0;
   logic        flip_h = 1'b0;
   logic [18:0] rom_addr, fb_addr;
   logic [23:0] rom_data = '0, fb_data;
   logic        fb_we, busy, done;

   logic [23:0] rom [0:1023];

   int nvec = 0, nerr = 0;
   int l_ra [0:15], l_fa [0:15], l_fd [0:15];
   int l_we [0:15], l_busy [0:15], l_done [0:15];

   int fa_basic [0:5] = '{3210, 3211, 3212, 3850, 3851, 3852};
   int ra_flip  [0:5] = '{102, 101, 100, 105, 104, 103};

   sprite_blitter dut (
      .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
      .spr_w(spr_w), .spr_h(spr_h), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
      .rom_addr(rom_addr), .rom_data(rom_data), .fb_addr(fb_addr), .fb_data(fb_data),
      .fb_we(fb_we), .busy(busy), .done(done)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) rom_data <= rom[rom_addr[9:0]];

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // start is high during cycle 0; cycle n is sampled on the falling edge after rising edge n
   task automatic run(input int b, input int w, input int h, input int x, input int y,
                      input int f, input int ncyc, input int pulse_at, input int rst_at);
      for (int i = 0; i < 16; i++) begin
         l_ra[i] = 0; l_fa[i] = 0; l_fd[i] = 0; l_we[i] = 0; l_busy[i] = 0; l_done[i] = 0;
      end
      @(posedge Clk); #1;
      base_addr = 19'(b); spr_w = 8'(w); spr_h = 8'(h);
      pos_x = 10'(x); pos_y = 10'(y); flip_h = f[0];
      start = 1'b1;
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge Clk); #1;
         start = (n == pulse_at);
         if (n == pulse_at) begin
            base_addr = 19'd0; spr_w = 8'd5; spr_h = 8'd5;
            pos_x = 10'd0; pos_y = 10'd0; flip_h = 1'b1;
         end
         Reset = (n == rst_at);
         @(negedge Clk);
         l_ra[n] = int'(rom_addr); l_fa[n] = int'(fb_addr); l_fd[n] = int'(fb_data);
         l_we[n] = int'(fb_we); l_busy[n] = int'(busy); l_done[n] = int'(done);
      end
   endtask

   function automatic int cnt_we(input int from);
      int c = 0;
      for (int i = from; i < 16; i++) c += l_we[i];
      return c;
   endfunction

   function automatic int cnt_busy();
      int c = 0;
      for (int i = 1; i < 16; i++) c += l_busy[i];
      return c;
   endfunction

   function automatic int cnt_done();
      int c = 0;
      for (int i = 1; i < 16; i++) c += l_done[i];
      return c;
   endfunction

   function automatic int done_at();
      for (int i = 1; i < 16; i++) if (l_done[i] != 0) return i;
      return -1;
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 24'h120000 | 24'(i);

      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      chk("rst_ra",   int'(rom_addr), 0);
      chk("rst_fa",   int'(fb_addr),  0);
      chk("rst_we",   int'(fb_we),    0);
      chk("rst_busy", int'(busy),     0);
      chk("rst_done", int'(done),     0);

      // basic 3x2 copy
      run(100, 3, 2, 10, 5, 0, 10, -1, -1);
      for (int i = 0; i < 6; i++) begin
         chk("b_ra", l_ra[i+1], 100 + i);
         chk("b_we", l_we[i+2], 1);
         chk("b_fa", l_fa[i+2], fa_basic[i]);
         chk("b_fd", l_fd[i+2], int'(rom[100+i]));
      end
      chk("b_we1",   l_we[1],   0);
      chk("b_we8",   l_we[8],   0);
      chk("b_busy1", l_busy[1], 1);
      chk("b_busy7", l_busy[7], 1);
      chk("b_busy8", l_busy[8], 0);
      chk("b_done",  done_at(), 8);
      chk("b_ndone", cnt_done(), 1);
      chk("b_nwr",   cnt_we(1), 6);

      // transparent key at ROM[101]
      rom[101] = 24'hFF00FF;
      run(100, 3, 2, 10, 5, 0, 10, -1, -1);
      for (int i = 0; i < 6; i++) chk("t_we", l_we[i+2], (i == 1) ? 0 : 1);
      chk("t_fa3",  l_fa[3],   3211);
      chk("t_done", done_at(), 8);
      rom[101] = 24'h120000 | 24'd101;

      // horizontal mirror
      run(100, 3, 2, 10, 5, 1, 10, -1, -1);
      for (int i = 0; i < 6; i++) begin
         chk("f_ra", l_ra[i+1], ra_flip[i]);
         chk("f_fa", l_fa[i+2], fa_basic[i]);
         chk("f_fd", l_fd[i+2], int'(rom[ra_flip[i]]));
      end
      chk("f_done", done_at(), 8);

      // clipping at bottom-right corner
      run(200, 4, 1, 638, 479, 0, 10, -1, -1);
      for (int i = 0; i < 4; i++) chk("c_ra", l_ra[i+1], 200 + i);
      chk("c_ra5",  l_ra[5],   203);
      chk("c_we2",  l_we[2],   1);
      chk("c_fa2",  l_fa[2],   307198);
      chk("c_we3",  l_we[3],   1);
      chk("c_fa3",  l_fa[3],   307199);
      chk("c_nwr",  cnt_we(1), 2);
      chk("c_done", done_at(), 6);

      // start re-pulsed mid-copy is ignored
      run(100, 3, 2, 10, 5, 0, 12, 3, -1);
      chk("m_ra6",   l_ra[6],   105);
      chk("m_nwr",   cnt_we(1), 6);
      chk("m_done",  done_at(), 8);
      chk("m_ndone", cnt_done(), 1);

      // zero-width request
      run(100, 0, 5, 10, 5, 0, 6, -1, -1);
      chk("z_done",  done_at(),  1);
      chk("z_nwr",   cnt_we(1),  0);
      chk("z_busy",  cnt_busy(), 0);
      chk("z_ndone", cnt_done(), 1);

      // reset during cycle 3 aborts the copy
      run(100, 3, 2, 10, 5, 0, 10, -1, 3);
      chk("r_we3",   l_we[3],    1);
      chk("r_nwr",   cnt_we(4),  0);
      chk("r_busy4", l_busy[4],  0);
      chk("r_done",  done_at(),  -1);

      // fresh copy after the abort
      run(100, 3, 2, 10, 5, 0, 10, -1, -1);
      chk("a_ra1",  l_ra[1],   100);
      chk("a_fa2",  l_fa[2],   3210);
      chk("a_nwr",  cnt_we(1), 6);
      chk("a_done", done_at(), 8);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
